// File: rtl/prbs_pkg.sv
// Shared PRBS-8 definitions (x^8+x^6+x^5+x^4+1) for the checker and any matching generator.
// Holds the FSM state encoding, the tap mask, the default lock/loss thresholds and the feedback function.
package prbs_pkg;

    typedef enum logic [1:0] {
        ST_SEED   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    // Taps at s[7], s[5], s[4], s[3]
    localparam logic [7:0] PRBS_TAPS = 8'b1011_1000;

    localparam int LOCK_COUNT_DEF = 16;
    localparam int LOSS_COUNT_DEF = 4;

    function automatic logic prbs_fb(input logic [7:0] s);
        return ^(s & PRBS_TAPS);
    endfunction

endpackage

// File: rtl/prbs_checker.sv
// PRBS-8 stream checker: seed, verify and flywheel-lock FSM with error/bit counters.
// Latency: all outputs registered, updated one cycle after the beat; no backpressure, in_valid only qualifies beats.
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int LOCK_COUNT = LOCK_COUNT_DEF,
    parameter int LOSS_COUNT = LOSS_COUNT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic        in_bit,
    input  logic        clr_cnt,
    output logic        locked,
    output logic        err_pulse,
    output logic [15:0] err_count,
    output logic [31:0] bit_count
);

    localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam int MISS_W  = $clog2(LOSS_COUNT + 1);

    state_e             state_q, state_d;
    logic [7:0]         s_q, s_d;
    logic [3:0]         fill_q, fill_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic [MISS_W-1:0]  miss_q, miss_d;
    logic               locked_q, locked_d;
    logic               err_pulse_q, err_pulse_d;
    logic [15:0]        err_count_q, err_count_d;
    logic [31:0]        bit_count_q, bit_count_d;

    logic pred;
    logic mismatch;

    assign pred     = prbs_fb(s_q);
    assign mismatch = in_bit ^ pred;

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        fill_d      = fill_q;
        match_d     = match_q;
        miss_d      = miss_q;
        err_pulse_d = 1'b0;
        err_count_d = err_count_q;
        bit_count_d = bit_count_q;

        if (in_valid) begin
            unique case (state_q)
                ST_SEED: begin
                    s_d    = {s_q[6:0], in_bit};
                    fill_d = (fill_q == 4'd8) ? 4'd8 : fill_q + 4'd1;
                    // An all-zero register would predict zeros forever, so keep filling until a one arrives
                    if (fill_d == 4'd8 && s_d != 8'h00) begin
                        state_d = ST_VERIFY;
                        match_d = '0;
                    end
                end
                ST_VERIFY: begin
                    s_d = {s_q[6:0], in_bit};
                    if (mismatch) begin
                        state_d = ST_SEED;
                        fill_d  = 4'd0;
                    end else if (match_q == MATCH_W'(LOCK_COUNT - 1)) begin
                        state_d = ST_LOCKED;
                        miss_d  = '0;
                    end else begin
                        match_d = match_q + 1'b1;
                    end
                end
                ST_LOCKED: begin
                    // Flywheel: feed back the prediction so line errors never corrupt the state
                    s_d         = {s_q[6:0], pred};
                    bit_count_d = bit_count_q + 32'd1;
                    if (mismatch) begin
                        err_pulse_d = 1'b1;
                        if (err_count_q != 16'hFFFF) begin
                            err_count_d = err_count_q + 16'd1;
                        end
                        if (miss_q == MISS_W'(LOSS_COUNT - 1)) begin
                            state_d = ST_SEED;
                            fill_d  = 4'd0;
                            match_d = '0;
                            miss_d  = '0;
                        end else begin
                            miss_d = miss_q + 1'b1;
                        end
                    end else begin
                        miss_d = '0;
                    end
                end
                default: begin
                    state_d = ST_SEED;
                    fill_d  = 4'd0;
                end
            endcase
        end

        if (clr_cnt) begin
            err_count_d = 16'd0;
            bit_count_d = 32'd0;
        end

        locked_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_SEED;
            s_q         <= 8'h00;
            fill_q      <= 4'd0;
            match_q     <= '0;
            miss_q      <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_count_q <= 16'd0;
            bit_count_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            fill_q      <= fill_d;
            match_q     <= match_d;
            miss_q      <= miss_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
            bit_count_q <= bit_count_d;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;
    assign bit_count = bit_count_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: table of post-lock beats plus hand sequences for lock, loss, reset and gaps.
module tb_prbs_checker;
    import prbs_pkg::*;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_bit;
    logic        clr_cnt;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;
    logic [31:0] bit_count;

    int checks;
    int errors;

    logic [7:0] g;

    typedef struct {
        logic v;
        logic inv;
        logic clr;
        logic e_lock;
        logic e_pulse;
        int   e_err;
        int   e_bc;
    } vec_t;

    vec_t tbl[12];

    prbs_checker dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .clr_cnt   (clr_cnt),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count),
        .bit_count (bit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference generator: emits the prediction of its own history, then shifts it in.
    task automatic gen_bit(output logic b);
        b = prbs_fb(g);
        g = {g[6:0], b};
    endtask

    // Inputs change at the falling edge; outputs are sampled at the next falling edge.
    task automatic step(input logic v, input logic b, input logic c);
        in_valid = v;
        in_bit   = b;
        clr_cnt  = c;
        @(negedge clk);
    endtask

    task automatic clean_beats(input int n);
        logic b;
        for (int i = 0; i < n; i++) begin
            gen_bit(b);
            step(1'b1, b, 1'b0);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        reset = 1'b0;
    endtask

    initial begin
        logic b;
        int   bad_pulse;
        int   nvalid;
        int   seen_lock;

        checks   = 0;
        errors   = 0;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_bit   = 1'b0;
        clr_cnt  = 1'b0;
        g        = 8'h01;

        // {valid, invert, clr, locked, err_pulse, err_count, bit_count} after each beat, starting locked
        tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1, 1};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1, 2};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 2};
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0, 0};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1, 2};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1, 2};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2, 3};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3, 4};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4, 5};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4, 5};

        @(negedge clk);
        do_reset();
        chk("rst_locked", locked, 0);
        chk("rst_pulse", err_pulse, 0);
        chk("rst_err", err_count, 0);
        chk("rst_bits", bit_count, 0);

        // Clean stream: 8 seed + 16 verify beats, locked visible once the 24th beat is taken
        clean_beats(23);
        chk("lock_after_23", locked, 0);
        clean_beats(1);
        chk("lock_after_24", locked, 1);
        chk("lock_bits0", bit_count, 0);
        bad_pulse = 0;
        for (int i = 24; i < 1000; i++) begin
            clean_beats(1);
            if (err_pulse !== 1'b0 || locked !== 1'b1) bad_pulse++;
        end
        chk("clean_no_pulse", bad_pulse, 0);
        chk("clean_err", err_count, 0);
        chk("clean_bits", bit_count, 976);

        for (int i = 0; i < 12; i++) begin
            if (tbl[i].v) begin
                gen_bit(b);
                step(1'b1, b ^ tbl[i].inv, tbl[i].clr);
            end else begin
                step(1'b0, tbl[i].inv, tbl[i].clr);
            end
            chk($sformatf("tbl%0d_locked", i), locked, tbl[i].e_lock);
            chk($sformatf("tbl%0d_pulse", i), err_pulse, tbl[i].e_pulse);
            chk($sformatf("tbl%0d_err", i), err_count, tbl[i].e_err);
            chk($sformatf("tbl%0d_bits", i), bit_count, tbl[i].e_bc);
        end

        // Row 11 was the first reseed beat after loss; relock needs 24 beats in total
        clean_beats(22);
        chk("relock_after_23", locked, 0);
        clean_beats(1);
        chk("relock_after_24", locked, 1);
        chk("relock_err_kept", err_count, 4);
        chk("relock_bits_kept", bit_count, 5);

        // Reset wins over a counting, erroring beat
        gen_bit(b);
        reset = 1'b1;
        step(1'b1, ~b, 1'b0);
        reset = 1'b0;
        chk("midrst_locked", locked, 0);
        chk("midrst_pulse", err_pulse, 0);
        chk("midrst_err", err_count, 0);
        chk("midrst_bits", bit_count, 0);

        // Random idle cycles must not change the valid-beat count to lock
        do_reset();
        g         = 8'h01;
        nvalid    = 0;
        seen_lock = 0;
        for (int cyc = 0; cyc < 400 && nvalid < 24; cyc++) begin
            if ($urandom_range(0, 2) == 0) begin
                step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
                if (err_pulse !== 1'b0) bad_pulse++;
            end else begin
                clean_beats(1);
                nvalid++;
                if (nvalid == 23 && locked) seen_lock = 1;
            end
        end
        chk("gap_beats", nvalid, 24);
        chk("gap_early_lock", seen_lock, 0);
        chk("gap_locked", locked, 1);
        chk("gap_err", err_count, 0);
        chk("gap_idle_pulse", bad_pulse, 0);

        // All-zero input keeps the checker seeding
        do_reset();
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0);
        chk("zeros_locked", locked, 0);
        chk("zeros_bits", bit_count, 0);
        g         = 8'h01;
        seen_lock = 0;
        for (int i = 0; i < 300 && !seen_lock; i++) begin
            clean_beats(1);
            if (locked) seen_lock = 1;
        end
        chk("zeros_then_lock", seen_lock, 1);
        clean_beats(50);
        chk("zeros_then_err", err_count, 0);
        chk("zeros_then_bits", bit_count, 50);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
